sub0_field_extract: RTL and testbench

- Downstream stage of the sub0 segment parser.
- Consumes per-instruction parse actions (low action byte) paired with two consecutive 8-byte segment words.
- Extracts 2B/4B/8B header fields at the encoded byte offset and accumulates them into a packet header vector (PHV) register bank.
- At end of packet, publishes the PHV on a valid/ready output with one output register and drop accounting.

---
 rtl/sub0_field_extract_if.sv | 28 ++
 rtl/sub0_field_extract.sv | 211 +++++++++++++++++++++
 tb/tb_sub0_field_extract.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub0_field_extract_if.sv
// Bus bundle for sub0_field_extract: action/segment input side plus the PHV
// valid/ready output side.
interface sub0_field_extract_if #(
   parameter int CONT_NUM   = 8,
   parameter int PHV_WIDTH  = 896,
   parameter int DROP_CNT_W = 16
);
   logic [7:0]            i_act;
   logic                  i_act_valid;
   logic [63:0]           i_seg_lo;
   logic [63:0]           i_seg_hi;
   logic                  i_pkt_end;
   logic [PHV_WIDTH-1:0]  o_phv;
   logic [3*CONT_NUM-1:0] o_phv_vld_map;
   logic                  o_phv_valid;
   logic                  i_phv_ready;
   logic [DROP_CNT_W-1:0] o_drop_cnt;

   modport slave (
      input  i_act, i_act_valid, i_seg_lo, i_seg_hi, i_pkt_end, i_phv_ready,
      output o_phv, o_phv_vld_map, o_phv_valid, o_drop_cnt
   );

   modport master (
      output i_act, i_act_valid, i_seg_lo, i_seg_hi, i_pkt_end, i_phv_ready,
      input  o_phv, o_phv_vld_map, o_phv_valid, o_drop_cnt
   );
endinterface

// File: rtl/sub0_field_extract.sv
// sub0 field extractor: pulls 2B/4B/8B fields out of a 16-byte window into a
// PHV container bank and publishes the bank at end of packet.
module sub0_field_extract #(
   parameter int CONT_NUM   = 8,
   parameter int PHV_WIDTH  = 896,
   parameter int DROP_CNT_W = 16
) (
   input logic                 axis_clk,
   input logic                 aresetn,
   sub0_field_extract_if.slave bus
);

   typedef enum logic [1:0] {
      VT_NONE = 2'b00,
      VT_2B   = 2'b01,
      VT_4B   = 2'b10,
      VT_8B   = 2'b11
   } val_type_e;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   localparam int unsigned OFF4 = 16 * CONT_NUM;
   localparam int unsigned OFF8 = 48 * CONT_NUM;

   // ------------------------------------------------------------------
   // Field extraction from the 16-byte window
   // ------------------------------------------------------------------
   val_type_e   act_type;
   logic [127:0] win;
   logic [6:0]   win_sh;
   logic [63:0]  win_top;
   logic [63:0]  ext_val;

   assign act_type = val_type_e'(bus.i_act[1:0]);
   assign win      = {bus.i_seg_lo, bus.i_seg_hi};
   assign win_sh   = {1'b0, bus.i_act[7:5], 3'b000};
   // 64 bits starting at byte b; offsets never exceed 7 so this stays in range
   assign win_top  = win[7'd127 - win_sh -: 64];

   always_comb begin
      ext_val = '0;
      case (act_type)
         VT_2B:   ext_val = {48'd0, win_top[63:48]};
         VT_4B:   ext_val = {32'd0, win_top[63:32]};
         VT_8B:   ext_val = win_top;
         default: ext_val = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // S1 / S2 pipeline
   // ------------------------------------------------------------------
   logic        s1_we,  s2_we;
   logic [2:0]  s1_idx, s2_idx;
   val_type_e   s1_type, s2_type;
   logic [63:0] s1_val, s2_val;
   logic        s1_end, s2_end;

   always_ff @(posedge axis_clk) begin
      if (!aresetn) begin
         s1_we   <= 1'b0;
         s1_idx  <= '0;
         s1_type <= VT_NONE;
         s1_val  <= '0;
         s1_end  <= 1'b0;
         s2_we   <= 1'b0;
         s2_idx  <= '0;
         s2_type <= VT_NONE;
         s2_val  <= '0;
         s2_end  <= 1'b0;
      end else begin
         s1_we   <= bus.i_act_valid && (act_type != VT_NONE);
         s1_idx  <= bus.i_act[4:2];
         s1_type <= act_type;
         s1_val  <= ext_val;
         s1_end  <= bus.i_pkt_end;
         s2_we   <= s1_we;
         s2_idx  <= s1_idx;
         s2_type <= s1_type;
         s2_val  <= s1_val;
         s2_end  <= s1_end;
      end
   end

   // ------------------------------------------------------------------
   // Container bank and its merged next value
   // ------------------------------------------------------------------
   logic [15:0]           bank2 [CONT_NUM];
   logic [31:0]           bank4 [CONT_NUM];
   logic [63:0]           bank8 [CONT_NUM];
   logic [3*CONT_NUM-1:0] bank_map;

   logic [15:0]           nb2 [CONT_NUM];
   logic [31:0]           nb4 [CONT_NUM];
   logic [63:0]           nb8 [CONT_NUM];
   logic [3*CONT_NUM-1:0] nmap;
   logic [PHV_WIDTH-1:0]  phv_next;
   logic                  commit;

   assign commit = s2_end;

   always_comb begin
      nb2  = bank2;
      nb4  = bank4;
      nb8  = bank8;
      nmap = bank_map;
      if (s2_we) begin
         case (s2_type)
            VT_2B: begin
               nb2[s2_idx]            = s2_val[15:0];
               nmap[{2'b00, s2_idx}]  = 1'b1;
            end
            VT_4B: begin
               nb4[s2_idx]            = s2_val[31:0];
               nmap[{2'b01, s2_idx}]  = 1'b1;
            end
            VT_8B: begin
               nb8[s2_idx]            = s2_val;
               nmap[{2'b10, s2_idx}]  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      phv_next = '0;
      for (int unsigned i = 0; i < CONT_NUM; i++) begin
         phv_next[16*i +: 16]        = nb2[i];
         phv_next[OFF4 + 32*i +: 32] = nb4[i];
         phv_next[OFF8 + 64*i +: 64] = nb8[i];
      end
   end

   // The bank clears on every commit, whether the PHV is published or dropped
   always_ff @(posedge axis_clk) begin
      if (!aresetn || commit) begin
         bank2    <= '{default: '0};
         bank4    <= '{default: '0};
         bank8    <= '{default: '0};
         bank_map <= '0;
      end else begin
         bank2    <= nb2;
         bank4    <= nb4;
         bank8    <= nb8;
         bank_map <= nmap;
      end
   end

   // ------------------------------------------------------------------
   // Output slot FSM
   // ------------------------------------------------------------------
   slot_state_e state_q, state_d;
   logic        load_out;
   logic        drop_out;

   always_ff @(posedge axis_clk) begin
      if (!aresetn) state_q <= SLOT_EMPTY;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      load_out = 1'b0;
      drop_out = 1'b0;
      case (state_q)
         SLOT_EMPTY: begin
            if (commit) begin
               load_out = 1'b1;
               state_d  = SLOT_FULL;
            end
         end
         SLOT_FULL: begin
            if (commit) begin
               if (bus.i_phv_ready) load_out = 1'b1;
               else                 drop_out = 1'b1;
            end else if (bus.i_phv_ready) begin
               state_d = SLOT_EMPTY;
            end
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

   logic [PHV_WIDTH-1:0]  phv_q;
   logic [3*CONT_NUM-1:0] map_q;
   logic [DROP_CNT_W-1:0] drop_q;

   always_ff @(posedge axis_clk) begin
      if (!aresetn) begin
         phv_q  <= '0;
         map_q  <= '0;
         drop_q <= '0;
      end else begin
         if (load_out) begin
            phv_q <= phv_next;
            map_q <= nmap;
         end
         if (drop_out && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      end
   end

   assign bus.o_phv         = phv_q;
   assign bus.o_phv_vld_map = map_q;
   assign bus.o_phv_valid   = (state_q == SLOT_FULL);
   assign bus.o_drop_cnt    = drop_q;

endmodule

// File: tb/tb_sub0_field_extract.sv
// Self-checking bench for sub0_field_extract: directed cases with literal
// expectations plus randomized traffic against a byte-level packet model.
module tb_sub0_field_extract;

   logic axis_clk = 1'b0;
   logic aresetn  = 1'b0;
   always #5 axis_clk = ~axis_clk;

   sub0_field_extract_if bus ();

   sub0_field_extract #(
      .CONT_NUM   (8),
      .PHV_WIDTH  (896),
      .DROP_CNT_W (16)
   ) dut (
      .axis_clk (axis_clk),
      .aresetn  (aresetn),
      .bus      (bus.slave)
   );

   localparam logic [63:0] LO = 64'h0011223344556677;
   localparam logic [63:0] HI = 64'h8899AABBCCDDEEFF;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [895:0] got, input logic [895:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int            due;
      logic [895:0]  phv;
      logic [23:0]   map;
   } pend_t;

   logic [15:0]  m2 [8];
   logic [31:0]  m4 [8];
   logic [63:0]  m8 [8];
   logic [23:0]  mmap;
   pend_t        pend [$];
   logic         mvalid;
   logic [895:0] mphv;
   logic [23:0]  mmapo;
   int           mdrop;
   int           cyc_n = 0;

   function automatic logic [895:0] pack_phv();
      logic [895:0] v = '0;
      for (int i = 0; i < 8; i++) begin
         v[16*i +: 16]       = m2[i];
         v[128 + 32*i +: 32] = m4[i];
         v[384 + 64*i +: 64] = m8[i];
      end
      return v;
   endfunction

   function automatic void clear_pkt();
      for (int i = 0; i < 8; i++) begin
         m2[i] = '0; m4[i] = '0; m8[i] = '0;
      end
      mmap = '0;
   endfunction

   function automatic void apply_act(input logic [7:0] act, input logic [63:0] lo, input logic [63:0] hi);
      logic [7:0]  wb [16];
      logic [63:0] val = '0;
      int b   = int'(act[7:5]);
      int idx = int'(act[4:2]);
      int len = (act[1:0] == 2'd1) ? 2 : (act[1:0] == 2'd2) ? 4 : 8;
      for (int k = 0; k < 8; k++) begin
         wb[k]     = lo[63 - 8*k -: 8];
         wb[k + 8] = hi[63 - 8*k -: 8];
      end
      for (int j = 0; j < len; j++) val = (val << 8) | 64'(wb[b + j]);
      case (act[1:0])
         2'd1: begin m2[idx] = val[15:0]; mmap[idx]      = 1'b1; end
         2'd2: begin m4[idx] = val[31:0]; mmap[8 + idx]  = 1'b1; end
         2'd3: begin m8[idx] = val;       mmap[16 + idx] = 1'b1; end
         default: ;
      endcase
   endfunction

   // Model update at each edge, then compare DUT against it
   always @(posedge axis_clk) begin
      logic        s_rst_n, s_av, s_pe, s_rdy;
      logic [7:0]  s_act;
      logic [63:0] s_lo, s_hi;
      pend_t       e;
      s_rst_n = aresetn;
      s_av    = bus.i_act_valid;
      s_act   = bus.i_act;
      s_lo    = bus.i_seg_lo;
      s_hi    = bus.i_seg_hi;
      s_pe    = bus.i_pkt_end;
      s_rdy   = bus.i_phv_ready;
      if (s_rst_n !== 1'b1) begin
         clear_pkt();
         pend.delete();
         mvalid = 1'b0;
         mphv   = '0;
         mmapo  = '0;
         mdrop  = 0;
      end else begin
         if (pend.size() > 0 && pend[0].due == cyc_n) begin
            e = pend.pop_front();
            if (!mvalid || s_rdy) begin
               mvalid = 1'b1;
               mphv   = e.phv;
               mmapo  = e.map;
            end else if (mdrop < 65535) begin
               mdrop++;
            end
         end else if (mvalid && s_rdy) begin
            mvalid = 1'b0;
         end
         if (s_av && s_act[1:0] != 2'd0) apply_act(s_act, s_lo, s_hi);
         if (s_pe) begin
            e.due = cyc_n + 2;
            e.phv = pack_phv();
            e.map = mmap;
            pend.push_back(e);
            clear_pkt();
         end
      end
      cyc_n++;
      #1;
      check("m_valid", 896'(bus.o_phv_valid), 896'(mvalid));
      check("m_drop", 896'(bus.o_drop_cnt), 896'(mdrop));
      if (mvalid) begin
         check("m_phv", bus.o_phv, mphv);
         check("m_map", 896'(bus.o_phv_vld_map), 896'(mmapo));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [7:0] act, input logic av, input logic [63:0] lo,
                        input logic [63:0] hi, input logic pe, input logic rdy);
      @(negedge axis_clk);
      bus.i_act       = act;
      bus.i_act_valid = av;
      bus.i_seg_lo    = lo;
      bus.i_seg_hi    = hi;
      bus.i_pkt_end   = pe;
      bus.i_phv_ready = rdy;
      @(posedge axis_clk);
      #2;
   endtask

   task automatic idle(input logic rdy);
      drive(8'h00, 1'b0, 64'd0, 64'd0, 1'b0, rdy);
   endtask

   initial begin
      logic [895:0] exp_phv;
      bus.i_act = '0; bus.i_act_valid = 1'b0; bus.i_seg_lo = '0;
      bus.i_seg_hi = '0; bus.i_pkt_end = 1'b0; bus.i_phv_ready = 1'b1;
      aresetn = 1'b0;
      repeat (3) idle(1'b1);
      check("rst_valid", 896'(bus.o_phv_valid), 896'(0));
      check("rst_phv", bus.o_phv, '0);
      check("rst_map", 896'(bus.o_phv_vld_map), 896'(0));
      check("rst_drop", 896'(bus.o_drop_cnt), 896'(0));
      aresetn = 1'b1;
      idle(1'b1);

      // Single 2B field, latency 3 edges
      drive(8'h69, 1'b1, LO, HI, 1'b1, 1'b1);
      check("t1_lat0", 896'(bus.o_phv_valid), 896'(0));
      idle(1'b1);
      check("t1_lat1", 896'(bus.o_phv_valid), 896'(0));
      idle(1'b1);
      check("t1_valid", 896'(bus.o_phv_valid), 896'(1));
      check("t1_2b2", 896'(bus.o_phv[47:32]), 896'(16'h3344));
      check("t1_model_2b2", 896'(mphv[47:32]), 896'(16'h3344));
      check("t1_map", 896'(bus.o_phv_vld_map), 896'(24'h000004));
      idle(1'b1);
      check("t1_vlow", 896'(bus.o_phv_valid), 896'(0));

      // 8B spanning both words
      drive(8'hA3, 1'b1, LO, HI, 1'b1, 1'b1);
      idle(1'b1); idle(1'b1);
      check("t2_8b0", 896'(bus.o_phv[447:384]), 896'(64'h5566778899AABBCC));
      check("t2_model_8b0", 896'(mphv[447:384]), 896'(64'h5566778899AABBCC));
      check("t2_map", 896'(bus.o_phv_vld_map), 896'(24'h010000));
      idle(1'b1);

      // Edge-offset 4B
      drive(8'hFE, 1'b1, LO, HI, 1'b1, 1'b1);
      idle(1'b1); idle(1'b1);
      check("t3_4b7", 896'(bus.o_phv[383:352]), 896'(32'h778899AA));
      check("t3_model_4b7", 896'(mphv[383:352]), 896'(32'h778899AA));
      check("t3_map", 896'(bus.o_phv_vld_map), 896'(24'h008000));
      idle(1'b1);

      // Overwrite with zeros, then a type-00 action closing the packet
      drive(8'hFE, 1'b1, LO, HI, 1'b0, 1'b1);
      drive(8'hFE, 1'b1, 64'd0, 64'd0, 1'b0, 1'b1);
      drive(8'hFC, 1'b1, LO, HI, 1'b1, 1'b1);
      idle(1'b1); idle(1'b1);
      check("t3b_valid", 896'(bus.o_phv_valid), 896'(1));
      check("t3b_phv", bus.o_phv, '0);
      check("t3b_map", 896'(bus.o_phv_vld_map), 896'(24'h008000));
      idle(1'b1);

      // Backpressure and drop
      drive(8'h69, 1'b1, LO, HI, 1'b1, 1'b0);
      idle(1'b0); idle(1'b0);
      check("t4_a_valid", 896'(bus.o_phv_valid), 896'(1));
      check("t4_a_map", 896'(bus.o_phv_vld_map), 896'(24'h000004));
      drive(8'hA3, 1'b1, LO, HI, 1'b1, 1'b0);
      idle(1'b0); idle(1'b0);
      check("t4_drop", 896'(bus.o_drop_cnt), 896'(1));
      check("t4_model_drop", 896'(mdrop), 896'(1));
      check("t4_hold_map", 896'(bus.o_phv_vld_map), 896'(24'h000004));
      check("t4_hold_2b2", 896'(bus.o_phv[47:32]), 896'(16'h3344));
      check("t4_hold_valid", 896'(bus.o_phv_valid), 896'(1));
      idle(1'b1);
      check("t4_released", 896'(bus.o_phv_valid), 896'(0));
      drive(8'hFE, 1'b1, LO, HI, 1'b1, 1'b1);
      idle(1'b1); idle(1'b1);
      check("t4_c_valid", 896'(bus.o_phv_valid), 896'(1));
      check("t4_c_map", 896'(bus.o_phv_vld_map), 896'(24'h008000));
      check("t4_c_8b0", 896'(bus.o_phv[447:384]), 896'(0));

      // Back-to-back packets
      drive(8'h69, 1'b1, LO, HI, 1'b1, 1'b1);
      drive(8'hA3, 1'b1, LO, HI, 1'b1, 1'b1);
      idle(1'b1);
      check("t5_p1_valid", 896'(bus.o_phv_valid), 896'(1));
      check("t5_p1_map", 896'(bus.o_phv_vld_map), 896'(24'h000004));
      idle(1'b1);
      check("t5_p2_valid", 896'(bus.o_phv_valid), 896'(1));
      check("t5_p2_map", 896'(bus.o_phv_vld_map), 896'(24'h010000));
      check("t5_p2_2b2", 896'(bus.o_phv[47:32]), 896'(0));
      check("t5_p2_8b0", 896'(bus.o_phv[447:384]), 896'(64'h5566778899AABBCC));
      check("t5_drop", 896'(bus.o_drop_cnt), 896'(1));
      idle(1'b1);
      check("t5_vlow", 896'(bus.o_phv_valid), 896'(0));

      // Reset mid-packet
      drive(8'hA3, 1'b1, LO, HI, 1'b0, 1'b1);
      drive(8'hFE, 1'b1, LO, HI, 1'b0, 1'b1);
      aresetn = 1'b0;
      idle(1'b1);
      check("t6_rst_drop", 896'(bus.o_drop_cnt), 896'(0));
      check("t6_rst_valid", 896'(bus.o_phv_valid), 896'(0));
      aresetn = 1'b1;
      drive(8'h69, 1'b1, LO, HI, 1'b1, 1'b1);
      idle(1'b1); idle(1'b1);
      exp_phv = '0;
      exp_phv[47:32] = 16'h3344;
      check("t6_phv", bus.o_phv, exp_phv);
      check("t6_map", 896'(bus.o_phv_vld_map), 896'(24'h000004));
      check("t6_drop", 896'(bus.o_drop_cnt), 896'(0));
      check("t6_valid", 896'(bus.o_phv_valid), 896'(1));
      idle(1'b1);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         aresetn = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
         drive(8'($urandom),
               ($urandom_range(0, 9) < 6),
               {$urandom, $urandom},
               {$urandom, $urandom},
               ($urandom_range(0, 9) < 2),
               ($urandom_range(0, 9) < 6));
      end
      aresetn = 1'b1;
      repeat (5) idle(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
